// File: rtl/mem_access_unit_pkg.sv
// Shared types for the MEM stage: FSM state encoding and size-mask decoding.
// Size masks are low-aligned lane masks: 0..01 byte, 0..011 half, 1..1 word.
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } mau_state_e;

   localparam int unsigned MAX_LANES = 64;

   typedef struct packed {
      logic       valid;
      logic [2:0] size_log2;
   } sel_info_t;

   // Valid masks are 2^k contiguous low lanes, no wider than the bus.
   function automatic sel_info_t decode_sel(input logic [MAX_LANES-1:0] sel,
                                            input int unsigned         lanes);
      sel_info_t              info;
      logic [MAX_LANES-1:0]   mask;
      info = '0;
      for (int k = 0; k < 7; k++) begin
         mask = (MAX_LANES'(1) << (1 << k)) - MAX_LANES'(1);
         if ((32'd1 << k) <= lanes && sel == mask) begin
            info.valid     = 1'b1;
            info.size_log2 = 3'(k);
         end
      end
      return info;
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
// Purely combinational so it can be shared with other memory clients.
module mem_access_unit_lane_align #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W/8-1:0]         i_sel,
   input  logic [$clog2(DATA_W/8)-1:0] i_ofs,
   input  logic [DATA_W-1:0]           i_store_data,
   input  logic [DATA_W-1:0]           i_rdata,
   input  logic                        i_sign_ext,
   output logic [DATA_W/8-1:0]         o_we,
   output logic [DATA_W-1:0]           o_wdata,
   output logic [DATA_W-1:0]           o_load_data
);

   localparam int unsigned LANES = DATA_W / 8;

   logic [DATA_W-1:0] w_shifted;
   logic              w_sign;

   assign o_we      = i_sel << i_ofs;
   assign o_wdata   = i_store_data << {i_ofs, 3'b000};
   assign w_shifted = i_rdata >> {i_ofs, 3'b000};

   // Sign comes from the top byte of the access, i.e. the highest selected lane.
   always_comb begin
      w_sign      = 1'b0;
      o_load_data = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i_sel[i]) w_sign = w_shifted[8*i+7];
      end
      for (int i = 0; i < LANES; i++) begin
         o_load_data[8*i +: 8] = i_sel[i] ? w_shifted[8*i +: 8] : {8{w_sign & i_sign_ext}};
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues a registered req/ack transaction per load/store, stalls
// until the RAM acknowledges, and presents extended load data for one DONE cycle.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read_flag_in,
   input  logic                  mem_write_flag_in,
   input  logic                  mem_sign_ext_flag_in,
   input  logic [DATA_W/8-1:0]   mem_sel_in,
   input  logic [DATA_W-1:0]     mem_write_data,
   input  logic [DATA_W-1:0]     result_in,
   input  logic                  reg_write_en_in,
   input  logic [REG_ADDR_W-1:0] reg_write_addr_in,
   input  logic [ADDR_W-1:0]     current_pc_addr_in,
   input  logic                  flush,
   output logic                  ram_req,
   output logic [DATA_W/8-1:0]   ram_we,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   input  logic                  ram_ack,
   input  logic [DATA_W-1:0]     ram_rdata,
   output logic                  stall_req,
   output logic                  mem_load_flag,
   output logic [DATA_W-1:0]     result_out,
   output logic                  reg_write_en_out,
   output logic [REG_ADDR_W-1:0] reg_write_addr_out,
   output logic [ADDR_W-1:0]     current_pc_addr_out,
   output logic                  addr_err,
   output logic [ADDR_W-1:0]     bad_addr
);

   localparam int unsigned LANES = DATA_W / 8;
   localparam int unsigned OFS_W = $clog2(LANES);

   mau_state_e         r_state, w_state_next;
   logic               r_ram_req, r_kill, r_is_load, r_wb_en;
   logic [LANES-1:0]   r_ram_we;
   logic [ADDR_W-1:0]  r_ram_addr;
   logic [DATA_W-1:0]  r_ram_wdata, r_load_data;

   sel_info_t          w_sel_info;
   logic [ADDR_W-1:0]  w_eff_addr;
   logic [OFS_W-1:0]   w_ofs, w_size_mask;
   logic               w_acc, w_mis, w_accept, w_kill_now;
   logic               w_stall, w_addr_err, w_wb_en;
   logic [DATA_W-1:0]  w_result, w_wdata, w_load_data;
   logic [LANES-1:0]   w_we;

   assign w_sel_info  = decode_sel(MAX_LANES'(mem_sel_in), LANES);
   assign w_eff_addr  = ADDR_W'(result_in);
   assign w_ofs       = w_eff_addr[OFS_W-1:0];
   assign w_size_mask = OFS_W'((32'd1 << w_sel_info.size_log2) - 32'd1);
   assign w_acc       = (mem_read_flag_in | mem_write_flag_in) & w_sel_info.valid;
   assign w_mis       = |(w_ofs & w_size_mask);
   assign w_kill_now  = r_kill | flush;

   mem_access_unit_lane_align #(
      .DATA_W (DATA_W)
   ) u_lane_align (
      .i_sel        (mem_sel_in),
      .i_ofs        (w_ofs),
      .i_store_data (mem_write_data),
      .i_rdata      (ram_rdata),
      .i_sign_ext   (mem_sign_ext_flag_in),
      .o_we         (w_we),
      .o_wdata      (w_wdata),
      .o_load_data  (w_load_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StIdle;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      w_addr_err   = 1'b0;
      w_accept     = 1'b0;
      w_result     = result_in;
      w_wb_en      = reg_write_en_in;
      unique case (r_state)
         StIdle: begin
            if (w_acc) begin
               w_wb_en = 1'b0;
               if (w_mis) begin
                  w_addr_err = ~flush;
               end else if (!flush) begin
                  w_stall      = 1'b1;
                  w_accept     = 1'b1;
                  w_state_next = StBusy;
               end
            end
         end
         StBusy: begin
            w_wb_en = 1'b0;
            w_stall = 1'b1;
            if (ram_ack) begin
               // A killed transaction releases the pipeline on the ack itself.
               w_state_next = w_kill_now ? StIdle : StDone;
               w_stall      = ~w_kill_now;
            end
         end
         StDone: begin
            w_result     = r_is_load ? r_load_data : result_in;
            w_wb_en      = r_wb_en & ~flush;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ram_req   <= 1'b0;
         r_ram_we    <= '0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_load_data <= '0;
         r_kill      <= 1'b0;
         r_is_load   <= 1'b0;
         r_wb_en     <= 1'b0;
      end else if (w_accept) begin
         r_ram_req   <= 1'b1;
         r_ram_we    <= mem_write_flag_in ? w_we : '0;
         r_ram_addr  <= {w_eff_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
         r_ram_wdata <= mem_write_flag_in ? w_wdata : '0;
         r_is_load   <= mem_read_flag_in;
         r_wb_en     <= reg_write_en_in;
         r_kill      <= 1'b0;
      end else if (r_state == StBusy) begin
         if (flush) r_kill <= 1'b1;
         if (ram_ack) begin
            r_ram_req   <= 1'b0;
            r_ram_we    <= '0;
            r_load_data <= w_load_data;
         end
      end
   end

   assign ram_req             = r_ram_req;
   assign ram_we              = r_ram_we;
   assign ram_addr            = r_ram_addr;
   assign ram_wdata           = r_ram_wdata;
   assign stall_req           = w_stall & rst_n;
   assign addr_err            = w_addr_err & rst_n;
   assign bad_addr            = w_eff_addr;
   assign result_out          = w_result;
   assign reg_write_en_out    = w_wb_en;
   assign mem_load_flag       = mem_read_flag_in;
   assign reg_write_addr_out  = reg_write_addr_in;
   assign current_pc_addr_out = current_pc_addr_in;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver queues expected RAM requests and
// write-back events; monitors compare them as the DUT presents them.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read_flag_in = 1'b0, mem_write_flag_in = 1'b0, mem_sign_ext_flag_in = 1'b0;
   logic [3:0]  mem_sel_in = '0;
   logic [31:0] mem_write_data = '0, result_in = '0;
   logic        reg_write_en_in = 1'b0;
   logic [4:0]  reg_write_addr_in = '0;
   logic [31:0] current_pc_addr_in = '0;
   logic        flush = 1'b0;
   logic        ram_req, ram_ack = 1'b0;
   logic [3:0]  ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata = '0;
   logic        stall_req, mem_load_flag, reg_write_en_out, addr_err;
   logic [31:0] result_out, current_pc_addr_out, bad_addr;
   logic [4:0]  reg_write_addr_out;

   int          checks = 0;
   int          errors = 0;
   int          ack_delay = 1;
   logic [31:0] rdata_val = '0;

   typedef struct {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } ram_exp_t;

   typedef struct {
      logic [31:0] result;
      logic        wb;
      logic        err;
      logic [31:0] bad;
      int          stall;
   } wb_exp_t;

   typedef struct {
      logic        rd, wr, sext, wb;
      logic [3:0]  sel;
      logic [31:0] data, addr, rdata;
      int          ack, flush_at, rst_at;
      logic        exp_ram, exp_wb;
      ram_exp_t    ram;
      wb_exp_t     wbe;
   } op_t;

   ram_exp_t ram_q[$];
   wb_exp_t  wb_q[$];

   mem_access_unit #(
      .DATA_W     (32),
      .ADDR_W     (32),
      .REG_ADDR_W (5)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .mem_read_flag_in     (mem_read_flag_in),
      .mem_write_flag_in    (mem_write_flag_in),
      .mem_sign_ext_flag_in (mem_sign_ext_flag_in),
      .mem_sel_in           (mem_sel_in),
      .mem_write_data       (mem_write_data),
      .result_in            (result_in),
      .reg_write_en_in      (reg_write_en_in),
      .reg_write_addr_in    (reg_write_addr_in),
      .current_pc_addr_in   (current_pc_addr_in),
      .flush                (flush),
      .ram_req              (ram_req),
      .ram_we               (ram_we),
      .ram_addr             (ram_addr),
      .ram_wdata            (ram_wdata),
      .ram_ack              (ram_ack),
      .ram_rdata            (ram_rdata),
      .stall_req            (stall_req),
      .mem_load_flag        (mem_load_flag),
      .result_out           (result_out),
      .reg_write_en_out     (reg_write_en_out),
      .reg_write_addr_out   (reg_write_addr_out),
      .current_pc_addr_out  (current_pc_addr_out),
      .addr_err             (addr_err),
      .bad_addr             (bad_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic op_t mk(input logic rd, input logic wr, input logic sext,
                              input logic [3:0] sel, input logic [31:0] data,
                              input logic [31:0] addr, input logic wb, input int ack,
                              input logic [31:0] rdata, input int flush_at, input int rst_at);
      op_t o;
      o.rd = rd; o.wr = wr; o.sext = sext; o.sel = sel; o.data = data; o.addr = addr;
      o.wb = wb; o.ack = ack; o.rdata = rdata; o.flush_at = flush_at; o.rst_at = rst_at;
      o.exp_ram = 1'b0; o.exp_wb = 1'b0;
      o.ram = '{we: 4'h0, addr: 32'h0, wdata: 32'h0};
      o.wbe = '{result: 32'h0, wb: 1'b0, err: 1'b0, bad: 32'h0, stall: 0};
      return o;
   endfunction

   function automatic op_t with_ram(input op_t o, input logic [3:0] we, input logic [31:0] addr,
                                    input logic [31:0] wdata);
      o.exp_ram = 1'b1;
      o.ram     = '{we: we, addr: addr, wdata: wdata};
      return o;
   endfunction

   function automatic op_t with_wb(input op_t o, input logic [31:0] res, input logic wb,
                                   input logic err, input logic [31:0] bad, input int stall);
      o.exp_wb = 1'b1;
      o.wbe    = '{result: res, wb: wb, err: err, bad: bad, stall: stall};
      return o;
   endfunction

   task automatic drive_idle();
      mem_read_flag_in = 1'b0; mem_write_flag_in = 1'b0; mem_sign_ext_flag_in = 1'b0;
      mem_sel_in = '0; mem_write_data = '0; result_in = '0; reg_write_en_in = 1'b0;
      flush = 1'b0;
   endtask

   task automatic run(input op_t o);
      int k;
      @(posedge clk); #1;
      mem_read_flag_in = o.rd; mem_write_flag_in = o.wr; mem_sign_ext_flag_in = o.sext;
      mem_sel_in = o.sel; mem_write_data = o.data; result_in = o.addr;
      reg_write_en_in = o.wb; reg_write_addr_in = 5'd7; current_pc_addr_in = 32'h1000 + o.addr;
      ack_delay = o.ack; rdata_val = o.rdata;
      flush = (o.flush_at == 0);
      if (o.exp_ram) ram_q.push_back(o.ram);
      if (o.exp_wb) wb_q.push_back(o.wbe);
      k = 0;
      while (1'b1) begin
         @(negedge clk);
         if (!stall_req) break;
         if (k >= 40) begin
            checks++; errors++;
            $display("FAIL stall_timeout: stall_req still 1 after %0d cycles, required 0", k);
            break;
         end
         @(posedge clk); #1;
         k++;
         flush = (o.flush_at == k);
         if (o.rst_at == k) begin
            #1 rst_n = 1'b0;
            #1;
            check("reset_ram_req", 32'(ram_req), 32'h0);
            check("reset_stall", 32'(stall_req), 32'h0);
         end
      end
      @(posedge clk); #1;
      drive_idle();
      rst_n = 1'b1;
      @(negedge clk);
      check("after_ram_req", 32'(ram_req), 32'h0);
      check("after_ram_we", 32'(ram_we), 32'h0);
   endtask

   // RAM model: acks in the ack_delay-th cycle of a request.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk); #1;
         if (rst_n && ram_req) begin
            cnt++;
            ram_ack   = (cnt == ack_delay);
            ram_rdata = ram_ack ? rdata_val : 32'h0;
         end else begin
            cnt       = 0;
            ram_ack   = 1'b0;
            ram_rdata = 32'h0;
         end
      end
   end

   // Monitor: RAM request fields on every request cycle, write-back events when the
   // stage releases the pipeline, writes back or reports a misaligned address.
   initial begin
      int       run_len;
      logic     prev_req;
      ram_exp_t cur;
      wb_exp_t  e;
      run_len = 0; prev_req = 1'b0;
      cur = '{we: 4'h0, addr: 32'h0, wdata: 32'h0};
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run_len = 0; prev_req = 1'b0;
         end else begin
            if (ram_req) begin
               if (!prev_req) begin
                  if (ram_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL ram_unexpected: got request addr 0x%08h, required none", ram_addr);
                  end else cur = ram_q.pop_front();
               end
               check("ram_we", 32'(ram_we), 32'(cur.we));
               check("ram_addr", ram_addr, cur.addr);
               check("ram_wdata", ram_wdata, cur.wdata);
            end
            prev_req = ram_req;
            if (stall_req) run_len++;
            else begin
               if (run_len > 0 || reg_write_en_out || addr_err) begin
                  if (wb_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL wb_unexpected: got event wb=%0b err=%0b result=0x%08h, required none",
                              reg_write_en_out, addr_err, result_out);
                  end else begin
                     e = wb_q.pop_front();
                     check("result_out", result_out, e.result);
                     check("reg_write_en_out", 32'(reg_write_en_out), 32'(e.wb));
                     check("addr_err", 32'(addr_err), 32'(e.err));
                     check("stall_cycles", 32'(run_len), 32'(e.stall));
                     if (e.err) check("bad_addr", bad_addr, e.bad);
                  end
               end
               run_len = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ram_req", 32'(ram_req), 32'h0);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      check("rst_ram_addr", ram_addr, 32'h0);
      check("rst_ram_wdata", ram_wdata, 32'h0);
      check("rst_stall", 32'(stall_req), 32'h0);
      check("rst_addr_err", 32'(addr_err), 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // SW 0xAABBCCDD @0x100, ack in 2nd request cycle
      run(with_wb(with_ram(mk(0, 1, 0, 4'b1111, 32'hAABBCCDD, 32'h100, 0, 2, 0, -1, -1),
                           4'b1111, 32'h100, 32'hAABBCCDD), 32'h100, 0, 0, 0, 3));
      // SB @0x103
      run(with_wb(with_ram(mk(0, 1, 0, 4'b0001, 32'h34567812, 32'h103, 0, 1, 0, -1, -1),
                           4'b1000, 32'h100, 32'h12000000), 32'h103, 0, 0, 0, 2));
      // LH @0x102 signed / unsigned
      run(with_wb(with_ram(mk(1, 0, 1, 4'b0011, 0, 32'h102, 1, 1, 32'h80011234, -1, -1),
                           4'b0000, 32'h100, 32'h0), 32'hFFFF8001, 1, 0, 0, 2));
      run(with_wb(with_ram(mk(1, 0, 0, 4'b0011, 0, 32'h102, 1, 3, 32'h80011234, -1, -1),
                           4'b0000, 32'h100, 32'h0), 32'h00008001, 1, 0, 0, 4));
      // LW @0x102 misaligned
      run(with_wb(mk(1, 0, 0, 4'b1111, 0, 32'h102, 1, 1, 0, -1, -1), 32'h102, 0, 1, 32'h102, 0));
      // LB @0x40 flushed in BUSY, ack in 4th request cycle
      run(with_wb(with_ram(mk(1, 0, 1, 4'b0001, 0, 32'h40, 1, 4, 32'hFFFFFFFF, 1, -1),
                           4'b0000, 32'h40, 32'h0), 32'h40, 0, 0, 0, 4));
      // LW @0x200 abandoned by reset in BUSY, then a normal LW
      run(with_ram(mk(1, 0, 0, 4'b1111, 0, 32'h200, 1, 5, 0, -1, 2), 4'b0000, 32'h200, 32'h0));
      run(with_wb(with_ram(mk(1, 0, 0, 4'b1111, 0, 32'h200, 1, 1, 32'hDEADBEEF, -1, -1),
                           4'b0000, 32'h200, 32'h0), 32'hDEADBEEF, 1, 0, 0, 2));
      // LB / LBU on upper lanes
      run(with_wb(with_ram(mk(1, 0, 1, 4'b0001, 0, 32'h201, 1, 2, 32'h11228077, -1, -1),
                           4'b0000, 32'h200, 32'h0), 32'hFFFFFF80, 1, 0, 0, 3));
      run(with_wb(with_ram(mk(1, 0, 0, 4'b0001, 0, 32'h203, 1, 1, 32'hF1000000, -1, -1),
                           4'b0000, 32'h200, 32'h0), 32'h000000F1, 1, 0, 0, 2));
      // SH aligned and misaligned
      run(with_wb(with_ram(mk(0, 1, 0, 4'b0011, 32'h0000BEEF, 32'h102, 0, 1, 0, -1, -1),
                           4'b1100, 32'h100, 32'hBEEF0000), 32'h102, 0, 0, 0, 2));
      run(with_wb(mk(0, 1, 0, 4'b0011, 32'h0000BEEF, 32'h101, 0, 1, 0, -1, -1),
                  32'h101, 0, 1, 32'h101, 0));
      // Invalid mask: plain pass-through with write-back
      run(with_wb(mk(1, 0, 0, 4'b0101, 0, 32'h5555, 1, 1, 0, -1, -1), 32'h5555, 1, 0, 0, 0));
      // Flush during DONE suppresses write-back
      run(with_wb(with_ram(mk(1, 0, 0, 4'b1111, 0, 32'h300, 1, 1, 32'h0BADF00D, 2, -1),
                           4'b0000, 32'h300, 32'h0), 32'h0BADF00D, 0, 0, 0, 2));
      // Flush while IDLE drops the access entirely
      run(mk(1, 0, 0, 4'b1111, 0, 32'h300, 1, 1, 0, 0, -1));

      repeat (4) @(negedge clk);
      checks++;
      if (ram_q.size() != 0) begin
         errors++;
         $display("FAIL ram_queue_drained: got %0d pending, required 0", ram_q.size());
      end
      checks++;
      if (wb_q.size() != 0) begin
         errors++;
         $display("FAIL wb_queue_drained: got %0d pending, required 0", wb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
